// File: rtl/viterbi_burst_channel.sv
// Burst-error channel model sitting between the rate-1/2 convolutional
// encoder and the Viterbi decoder. Symbols pass through one register stage.
// At most one burst of bit[0] inversions is injected per window of WIN valid
// symbols. The burst position comes from a free-running 16-bit LFSR.
// Saturating counters record the symbols, bursts and flipped bits so the
// bench can do its BER accounting.
module viterbi_burst_channel #(
    parameter int          WIN       = 32,
    parameter int          BURST_LEN = 4,
    parameter logic [15:0] LFSR_SEED = 16'h0001,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [1:0]       sym_i,
    output logic             valid_o,
    output logic [1:0]       sym_o,
    output logic [1:0]       err_mask_o,
    output logic [CNT_W-1:0] burst_ct_o,
    output logic [CNT_W-1:0] bit_err_ct_o,
    output logic [CNT_W-1:0] sym_ct_o
);

    localparam int PW = $clog2(WIN);
    localparam int RW = $clog2(BURST_LEN + 1);
    localparam logic [PW-1:0] MAX_START = PW'(WIN - BURST_LEN);
    localparam logic [RW-1:0] BL_M1     = RW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ARMED, BURST} state_t;

    state_t          state, state_nxt;
    logic [15:0]     lfsr;
    logic [PW-1:0]   pos;
    logic [PW-1:0]   start_r, start_nxt;
    logic [RW-1:0]   burst_rem, rem_nxt;
    logic            win_start;
    logic            trig;
    logic [PW-1:0]   raw;
    logic [PW-1:0]   start_calc;
    logic            corrupt;
    logic            first;

    // Saturating increment: the counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    assign win_start  = valid_i && (pos == '0);
    assign trig       = lfsr[0];
    assign raw        = lfsr[PW:1];
    // Clamp the start so that a burst always ends inside its own window.
    assign start_calc = (raw > MAX_START) ? MAX_START : raw;

    // Burst scheduling: decide whether the current symbol is corrupted and pick the next FSM state.
    always_comb begin
        state_nxt = state;
        rem_nxt   = burst_rem;
        start_nxt = start_r;
        corrupt   = 1'b0;
        first     = 1'b0;
        if (!en_i) begin
            // Disabling aborts any pending or running burst; it is not resumed later.
            state_nxt = IDLE;
            rem_nxt   = '0;
        end else if (valid_i) begin
            case (state)
                IDLE: begin
                    if (win_start && trig) begin
                        if (start_calc == '0) begin
                            corrupt   = 1'b1;
                            first     = 1'b1;
                            rem_nxt   = BL_M1;
                            state_nxt = (BL_M1 == '0) ? IDLE : BURST;
                        end else begin
                            start_nxt = start_calc;
                            state_nxt = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (pos == start_r) begin
                        corrupt   = 1'b1;
                        first     = 1'b1;
                        rem_nxt   = BL_M1;
                        state_nxt = (BL_M1 == '0) ? IDLE : BURST;
                    end
                end
                BURST: begin
                    corrupt = 1'b1;
                    rem_nxt = burst_rem - 1'b1;
                    if (burst_rem == RW'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control state: FSM, window position and LFSR. Everything freezes while valid_i is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_rem <= '0;
            start_r   <= '0;
            pos       <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            state     <= state_nxt;
            burst_rem <= rem_nxt;
            start_r   <= start_nxt;
            if (valid_i) begin
                pos <= pos + 1'b1;
            end
            // The LFSR advances at every window start, even when injection is disabled.
            if (win_start) begin
                lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
        end
    end

    // Output stage: registered symbol, error mask and statistics, all updated only on valid_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o      <= 1'b0;
            sym_o        <= 2'b00;
            err_mask_o   <= 2'b00;
            burst_ct_o   <= '0;
            bit_err_ct_o <= '0;
            sym_ct_o     <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sym_o        <= corrupt ? {sym_i[1], ~sym_i[0]} : sym_i;
                err_mask_o   <= corrupt ? 2'b01 : 2'b00;
                burst_ct_o   <= sat_inc(burst_ct_o, first);
                bit_err_ct_o <= sat_inc(bit_err_ct_o, corrupt);
                sym_ct_o     <= sat_inc(sym_ct_o, 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_viterbi_burst_channel.sv
// Directed bench for viterbi_burst_channel. Two instances share the stimulus:
// dut uses seed 16'h0001, so window 0 has a burst starting at symbol 0.
// dut_c uses seed 16'h003F, so the window-0 start is clamped from 31 to 28.
// For dut_c the LFSR steps to 16'h001F, which gives a window-1 burst at symbols 15..18.
module tb_viterbi_burst_channel;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  sym_i = 2'b00;

    logic        valid_o, c_valid_o;
    logic [1:0]  sym_o, c_sym_o;
    logic [1:0]  err_mask_o, c_err_mask_o;
    logic [15:0] burst_ct_o, c_burst_ct_o;
    logic [15:0] bit_err_ct_o, c_bit_err_ct_o;
    logic [15:0] sym_ct_o, c_sym_ct_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    viterbi_burst_channel #(
        .WIN(32), .BURST_LEN(4), .LFSR_SEED(16'h0001), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(valid_o), .sym_o(sym_o), .err_mask_o(err_mask_o),
        .burst_ct_o(burst_ct_o), .bit_err_ct_o(bit_err_ct_o), .sym_ct_o(sym_ct_o)
    );

    viterbi_burst_channel #(
        .WIN(32), .BURST_LEN(4), .LFSR_SEED(16'h003F), .CNT_W(16)
    ) dut_c (
        .clk(clk), .rst(rst), .en_i(en_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(c_valid_o), .sym_o(c_sym_o), .err_mask_o(c_err_mask_o),
        .burst_ct_o(c_burst_ct_o), .bit_err_ct_o(c_bit_err_ct_o), .sym_ct_o(c_sym_ct_o)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_i = 1'b0;
        sym_i = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle, then sample 1 time unit after the capturing edge.
    task automatic send(input logic v, input logic [1:0] s);
        @(negedge clk);
        valid_i = v;
        sym_i = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({valid_o, sym_o, err_mask_o, burst_ct_o, bit_err_ct_o, sym_ct_o} !== '0) begin
            bad++;
            $display("FAIL reset_dut: vld=%b sym=%b mask=%b b=%0d e=%0d s=%0d, want all 0",
                     valid_o, sym_o, err_mask_o, burst_ct_o, bit_err_ct_o, sym_ct_o);
        end
        total++;
        if ({c_valid_o, c_sym_o, c_err_mask_o, c_burst_ct_o, c_bit_err_ct_o, c_sym_ct_o} !== '0) begin
            bad++;
            $display("FAIL reset_dut_c: vld=%b sym=%b mask=%b b=%0d e=%0d s=%0d, want all 0",
                     c_valid_o, c_sym_o, c_err_mask_o, c_burst_ct_o, c_bit_err_ct_o, c_sym_ct_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        do_reset();
        en_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            send(1'b1, 2'b10);
            total++;
            if (valid_o !== 1'b1 || sym_o !== 2'b10 || err_mask_o !== 2'b00) begin
                bad++;
                $display("FAIL passthrough sym%0d: vld=%b sym=%b mask=%b, want 1 10 00",
                         i, valid_o, sym_o, err_mask_o);
            end
        end
        total++;
        if (burst_ct_o !== 16'd0 || bit_err_ct_o !== 16'd0 || sym_ct_o !== 16'd64) begin
            bad++;
            $display("FAIL passthrough_counts: b=%0d e=%0d s=%0d, want 0 0 64",
                     burst_ct_o, bit_err_ct_o, sym_ct_o);
        end
    endtask

    task automatic test_start_zero();
        logic [1:0] exp_sym;
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send(1'b1, 2'b00);
            exp_sym = (i < 4) ? 2'b01 : 2'b00;
            total++;
            if (valid_o !== 1'b1 || sym_o !== exp_sym || err_mask_o !== exp_sym) begin
                bad++;
                $display("FAIL start_zero sym%0d: vld=%b sym=%b mask=%b, want 1 %b %b",
                         i, valid_o, sym_o, err_mask_o, exp_sym, exp_sym);
            end
        end
        total++;
        if (burst_ct_o !== 16'd1 || bit_err_ct_o !== 16'd4 || sym_ct_o !== 16'd32) begin
            bad++;
            $display("FAIL start_zero_counts: b=%0d e=%0d s=%0d, want 1 4 32",
                     burst_ct_o, bit_err_ct_o, sym_ct_o);
        end
    endtask

    task automatic test_clamp();
        logic [1:0] exp_sym;
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(1'b1, 2'b00);
            exp_sym = ((i >= 28 && i <= 31) || (i >= 47 && i <= 50)) ? 2'b01 : 2'b00;
            total++;
            if (c_sym_o !== exp_sym || c_err_mask_o !== exp_sym) begin
                bad++;
                $display("FAIL clamp sym%0d: sym=%b mask=%b, want %b %b",
                         i, c_sym_o, c_err_mask_o, exp_sym, exp_sym);
            end
            if (i == 31) begin
                total++;
                if (c_burst_ct_o !== 16'd1 || c_bit_err_ct_o !== 16'd4) begin
                    bad++;
                    $display("FAIL clamp_win0_counts: b=%0d e=%0d, want 1 4",
                             c_burst_ct_o, c_bit_err_ct_o);
                end
            end
        end
        total++;
        if (c_burst_ct_o !== 16'd2 || c_bit_err_ct_o !== 16'd8 || c_sym_ct_o !== 16'd64) begin
            bad++;
            $display("FAIL clamp_counts: b=%0d e=%0d s=%0d, want 2 8 64",
                     c_burst_ct_o, c_bit_err_ct_o, c_sym_ct_o);
        end
    endtask

    task automatic test_gaps();
        logic [1:0] exp_sym;
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(1'b1, 2'b00);
            total++;
            if (valid_o !== 1'b1 || sym_o !== 2'b01) begin
                bad++;
                $display("FAIL gaps_pre sym%0d: vld=%b sym=%b, want 1 01", i, valid_o, sym_o);
            end
        end
        for (int g = 0; g < 3; g++) begin
            send(1'b0, 2'b11);
            total++;
            if (valid_o !== 1'b0 || sym_o !== 2'b01 || err_mask_o !== 2'b01) begin
                bad++;
                $display("FAIL gaps_hold cyc%0d: vld=%b sym=%b mask=%b, want 0 01 01",
                         g, valid_o, sym_o, err_mask_o);
            end
        end
        for (int i = 2; i < 32; i++) begin
            send(1'b1, 2'b00);
            exp_sym = (i < 4) ? 2'b01 : 2'b00;
            total++;
            if (valid_o !== 1'b1 || sym_o !== exp_sym || err_mask_o !== exp_sym) begin
                bad++;
                $display("FAIL gaps sym%0d: vld=%b sym=%b mask=%b, want 1 %b %b",
                         i, valid_o, sym_o, err_mask_o, exp_sym, exp_sym);
            end
        end
        total++;
        if (burst_ct_o !== 16'd1 || bit_err_ct_o !== 16'd4 || sym_ct_o !== 16'd32) begin
            bad++;
            $display("FAIL gaps_counts: b=%0d e=%0d s=%0d, want 1 4 32",
                     burst_ct_o, bit_err_ct_o, sym_ct_o);
        end
    endtask

    task automatic test_abort();
        logic [1:0] exp_sym;
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 2) en_i = 1'b0;
            if (i == 10) en_i = 1'b1;
            send(1'b1, 2'b00);
            exp_sym = (i < 2) ? 2'b01 : 2'b00;
            total++;
            if (sym_o !== exp_sym || err_mask_o !== exp_sym) begin
                bad++;
                $display("FAIL abort sym%0d: sym=%b mask=%b, want %b %b",
                         i, sym_o, err_mask_o, exp_sym, exp_sym);
            end
        end
        total++;
        if (burst_ct_o !== 16'd1 || bit_err_ct_o !== 16'd2 || sym_ct_o !== 16'd32) begin
            bad++;
            $display("FAIL abort_counts: b=%0d e=%0d s=%0d, want 1 2 32",
                     burst_ct_o, bit_err_ct_o, sym_ct_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] exp_sym;
        do_reset();
        en_i = 1'b1;
        send(1'b1, 2'b00);
        send(1'b1, 2'b00);
        @(negedge clk);
        valid_i = 1'b1;
        sym_i = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({valid_o, sym_o, err_mask_o, burst_ct_o, bit_err_ct_o, sym_ct_o} !== '0) begin
            bad++;
            $display("FAIL reset_mid_async: vld=%b sym=%b mask=%b b=%0d e=%0d s=%0d, want all 0",
                     valid_o, sym_o, err_mask_o, burst_ct_o, bit_err_ct_o, sym_ct_o);
        end
        @(negedge clk);
        rst = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send(1'b1, 2'b00);
            exp_sym = (i < 4) ? 2'b01 : 2'b00;
            total++;
            if (sym_o !== exp_sym || err_mask_o !== exp_sym) begin
                bad++;
                $display("FAIL reset_mid_replay sym%0d: sym=%b mask=%b, want %b %b",
                         i, sym_o, err_mask_o, exp_sym, exp_sym);
            end
        end
        total++;
        if (burst_ct_o !== 16'd1 || bit_err_ct_o !== 16'd4 || sym_ct_o !== 16'd32) begin
            bad++;
            $display("FAIL reset_mid_counts: b=%0d e=%0d s=%0d, want 1 4 32",
                     burst_ct_o, bit_err_ct_o, sym_ct_o);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_start_zero();
        test_clamp();
        test_gaps();
        test_abort();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/viterbi_burst_channel.md
Name: viterbi_burst_channel

Overview:
Programmable burst-error channel model placed between the rate-1/2 convolutional encoder and the Viterbi decoder. It accepts 2-bit encoded symbols with a valid strobe and forwards them after one register stage. It injects deterministic pseudo-random bursts of bit[0] inversions: at most one burst per window of WIN valid symbols. It also keeps statistics for bench-side BER accounting.

Parameters:
WIN, 32, window length in valid symbols; power of 2, range 8..256
BURST_LEN, 4, consecutive valid symbols corrupted per burst; 1..WIN
LFSR_SEED, 16'h0001, LFSR reset value; must be nonzero
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
en_i  in  1  error injection enable; 0 = clean passthrough
valid_i  in  1  sym_i qualifier (encoder valid output)
sym_i  in  2  encoded symbol from encoder
valid_o  out  1  sym_o qualifier (decoder enable)
sym_o  out  2  possibly corrupted symbol to decoder
err_mask_o  out  2  bits inverted on current sym_o (2'b01 or 2'b00)
burst_ct_o  out  CNT_W  bursts started since reset, saturating
bit_err_ct_o  out  CNT_W  bits inverted since reset, saturating
sym_ct_o  out  CNT_W  valid symbols forwarded since reset, saturating

Behaviour:
- Reset (async, while rst=1): all outputs 0; lfsr=LFSR_SEED; pos=0; burst_rem=0; state=IDLE. Reset mid-burst aborts the burst. After release, the sequence replays identically from the seed.
- Latency: exactly 1 clk. valid_o(t+1)=valid_i(t). sym_o and err_mask_o update only when valid_i=1 and hold otherwise. The statistics counters also advance only on valid_i.
- pos: log2(WIN)-bit counter of accepted valid symbols. It increments on valid_i and wraps WIN-1 -> 0. A window start is valid_i && pos==0.
- LFSR: 16-bit Fibonacci. On advance: lfsr <= {lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5], lfsr[15:1]}. It advances once per window start regardless of en_i, so the sequence does not depend on enable history.
- Decision at window start uses the pre-advance lfsr:
  - trig = lfsr[0]
  - raw = lfsr[log2(WIN):1]
  - start = min(raw, WIN-BURST_LEN), so a burst never crosses a window boundary
- FSM states: IDLE, ARMED, BURST.
  - IDLE -> ARMED: window start with en_i=1 and trig=1 and start>0; latch start.
  - IDLE -> BURST: same condition but start=0; the current symbol is the first corrupted one.
  - ARMED -> BURST: on the valid symbol where pos==start; that symbol is corrupted.
  - BURST: each valid symbol is corrupted and burst_rem decrements. The state returns to IDLE after BURST_LEN corrupted symbols; with BURST_LEN=1 it never lingers.
  - Any state -> IDLE: en_i=0 sampled on any cycle. The current symbol passes clean and burst_ct_o is not decremented.
- Corruption: sym_o <= {sym_i[1], ~sym_i[0]}, err_mask_o <= 2'b01. Otherwise sym_o <= sym_i, err_mask_o <= 2'b00.
- Counters: burst_ct_o +1 on the first corrupted symbol of a burst. bit_err_ct_o +1 per corrupted symbol. sym_ct_o +1 per valid symbol. All saturate at all-ones with no wrap.
- valid_i=0 cycles: FSM, pos and lfsr are frozen. Gaps do not consume burst length.
- en_i toggling back to 1 mid-window: no burst until the next window start.

Test Plan:
- Passthrough: rst pulse, en_i=0, 64 consecutive valid_i with sym_i=2'b10 -> sym_o=2'b10 one clk later on every symbol. err_mask_o=0, burst_ct_o=0, bit_err_ct_o=0, sym_ct_o=64.
- Start-at-zero burst: LFSR_SEED=16'h0001, en_i=1, sym_i=2'b00 for 32 valid -> window-0 symbols 0..3 emerge as 2'b01 with err_mask_o=2'b01, symbols 4..31 as 2'b00. burst_ct_o=1, bit_err_ct_o=4.
- Clamp: LFSR_SEED=16'h003F, en_i=1, 64 valid symbols -> symbols 28..31 corrupted, start clamped from 31. Nothing from this burst spills into window 1. bit_err_ct_o counts only 4 for window 0.
- Valid gaps: as the start-at-zero case but valid_i low for 3 cycles after the 2nd symbol -> exactly 4 symbols corrupted. valid_o mirrors valid_i delayed by 1; sym_o holds during gaps.
- Abort: as the start-at-zero case, drop en_i after 2 corrupted symbols -> symbols 2..31 clean. burst_ct_o=1, bit_err_ct_o=2, FSM in IDLE. Re-raise en_i mid-window -> no injection before the next window start.
- Reset mid-burst: assert rst during the 3rd corrupted symbol -> all outputs 0 immediately, without waiting for clk. After release, the identical corruption pattern and counts reproduce from the seed.
